// File: rtl/ctrl_pkg.sv
// Shared constants for the multi-cycle MIPS control unit: FSM states, ALU codes,
// datapath mux selects, opcodes/functs and the decoded-instruction record.
package ctrl_pkg;

    typedef enum logic [2:0] {
        StFetch, StDecode, StExec, StMem, StMemWb, StAluWb, StTrap
    } state_e;

    localparam logic [3:0] AluNop = 4'd0, AluAdd = 4'd1, AluSub = 4'd2, AluAnd = 4'd3,
                           AluOr  = 4'd4, AluSlt = 4'd5, AluSltu = 4'd6, AluSll = 4'd7,
                           AluSrl = 4'd8, AluSra = 4'd9, AluNor = 4'd10, AluXor = 4'd11,
                           AluLui = 4'd12;

    localparam logic [1:0] NpcPlus4 = 2'b00, NpcBranch = 2'b01, NpcJump = 2'b10, NpcJreg = 2'b11;
    localparam logic [1:0] GprRd = 2'b00, GprRt = 2'b01, GprRa = 2'b10;
    localparam logic [1:0] WdAlu = 2'b00, WdMem = 2'b01, WdPc = 2'b10;
    localparam logic [1:0] MwWord = 2'b00, MwHalf = 2'b01, MwByte = 2'b10;

    localparam logic [5:0] OpRtype = 6'h00, OpJ = 6'h02, OpJal = 6'h03, OpBeq = 6'h04,
                           OpBne = 6'h05, OpAddi = 6'h08, OpSlti = 6'h0A, OpAndi = 6'h0C,
                           OpOri = 6'h0D, OpLui = 6'h0F, OpLb = 6'h20, OpLh = 6'h21,
                           OpLw = 6'h23, OpLbu = 6'h24, OpLhu = 6'h25, OpSb = 6'h28,
                           OpSh = 6'h29, OpSw = 6'h2B;

    localparam logic [5:0] FnSll = 6'h00, FnSrl = 6'h02, FnSra = 6'h03, FnSllv = 6'h04,
                           FnSrlv = 6'h06, FnSrav = 6'h07, FnJr = 6'h08, FnJalr = 6'h09,
                           FnAdd = 6'h20, FnAddu = 6'h21, FnSub = 6'h22, FnSubu = 6'h23,
                           FnAnd = 6'h24, FnOr = 6'h25, FnXor = 6'h26, FnNor = 6'h27,
                           FnSlt = 6'h2A, FnSltu = 6'h2B;

    typedef struct packed {
        logic       is_rtype;
        logic       is_jump;
        logic       is_jal;
        logic       is_branch;
        logic       is_bne;
        logic       is_jr;
        logic       is_jalr;
        logic       is_load;
        logic       is_store;
        logic [1:0] mem_width;
        logic       mem_unsigned;
        logic [3:0] alu_op;
        logic       alu_src;
        logic       areg_sel;
        logic       ext_op;
        logic       illegal;
    } dec_t;

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction decoder: opcode/funct to instruction-class flags,
// per-instruction ALU controls and an illegal-instruction flag.
module mc_decode
    import ctrl_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] funct,
    output dec_t       dec
);

    always_comb begin
        dec = '0;
        unique case (op)
            OpRtype: begin
                dec.is_rtype = 1'b1;
                unique case (funct)
                    FnAdd, FnAddu: dec.alu_op = AluAdd;
                    FnSub, FnSubu: dec.alu_op = AluSub;
                    FnAnd:         dec.alu_op = AluAnd;
                    FnOr:          dec.alu_op = AluOr;
                    FnXor:         dec.alu_op = AluXor;
                    FnNor:         dec.alu_op = AluNor;
                    FnSlt:         dec.alu_op = AluSlt;
                    FnSltu:        dec.alu_op = AluSltu;
                    FnSll:  begin dec.alu_op = AluSll; dec.areg_sel = 1'b1; end
                    FnSrl:  begin dec.alu_op = AluSrl; dec.areg_sel = 1'b1; end
                    FnSra:  begin dec.alu_op = AluSra; dec.areg_sel = 1'b1; end
                    FnSllv:        dec.alu_op = AluSll;
                    FnSrlv:        dec.alu_op = AluSrl;
                    FnSrav:        dec.alu_op = AluSra;
                    FnJr:          dec.is_jr = 1'b1;
                    FnJalr:        dec.is_jalr = 1'b1;
                    default:       dec.illegal = 1'b1;
                endcase
            end
            OpJ:    dec.is_jump = 1'b1;
            OpJal:  begin dec.is_jump = 1'b1; dec.is_jal = 1'b1; end
            OpBeq, OpBne: begin
                dec.is_branch = 1'b1;
                dec.is_bne    = (op == OpBne);
                dec.alu_op    = AluSub;
                dec.ext_op    = 1'b1;
            end
            OpAddi: begin dec.alu_op = AluAdd; dec.alu_src = 1'b1; dec.ext_op = 1'b1; end
            OpSlti: begin dec.alu_op = AluSlt; dec.alu_src = 1'b1; dec.ext_op = 1'b1; end
            OpAndi: begin dec.alu_op = AluAnd; dec.alu_src = 1'b1; end
            OpOri:  begin dec.alu_op = AluOr;  dec.alu_src = 1'b1; end
            OpLui:  begin dec.alu_op = AluLui; dec.alu_src = 1'b1; end
            OpLb, OpLh, OpLw, OpLbu, OpLhu, OpSb, OpSh, OpSw: begin
                dec.is_load      = (op[3] == 1'b0);
                dec.is_store     = (op[3] == 1'b1);
                dec.mem_width    = (op[1:0] == 2'b00) ? MwByte :
                                   (op[1:0] == 2'b01) ? MwHalf : MwWord;
                dec.mem_unsigned = (op == OpLbu) || (op == OpLhu);
                dec.alu_op       = AluAdd;
                dec.alu_src      = 1'b1;
                dec.ext_op       = 1'b1;
            end
            default: dec.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control FSM: sequences each instruction over 2-5 cycles with a
// ready handshake on memory, a wait-state timeout and a sticky trap.
module mc_ctrl
    import ctrl_pkg::*;
#(
    parameter int unsigned ALUOP_W = 4,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [5:0]         Op,
    input  logic [5:0]         Funct,
    input  logic               Zero,
    input  logic               mem_ready,
    output logic               PCWrite,
    output logic [1:0]         NPCOp,
    output logic               IRWrite,
    output logic               MemRead,
    output logic               MemWrite,
    output logic [1:0]         MemWidth,
    output logic               MemUnsigned,
    output logic               RegWrite,
    output logic [1:0]         GPRSel,
    output logic [1:0]         WDSel,
    output logic               ALUSrc,
    output logic               AregSel,
    output logic               EXTOp,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic               retire,
    output logic               trap,
    output logic               trap_cause
);

    localparam int unsigned CntW = $clog2(TIMEOUT + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

    state_e        state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic          cause_q, cause_d;
    dec_t          dec;

    mc_decode u_decode (
        .op    (Op),
        .funct (Funct),
        .dec   (dec)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= StFetch;
            cnt_q   <= '0;
            cause_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cause_q <= cause_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        cause_d = cause_q;
        PCWrite = 1'b0; NPCOp = NpcPlus4; IRWrite = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
        MemWidth = MwWord; MemUnsigned = 1'b0; RegWrite = 1'b0; GPRSel = GprRd; WDSel = WdAlu;
        ALUSrc = 1'b0; AregSel = 1'b0; EXTOp = 1'b0; ALUOp = '0; retire = 1'b0;
        trap = 1'b0; trap_cause = 1'b0;

        unique case (state_q)
            StFetch: begin
                MemRead = 1'b1;
                if (mem_ready) begin
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                    state_d = StDecode;
                end else if (cnt_q == CntLast) begin
                    state_d = StTrap;
                    cause_d = 1'b1;
                end
            end
            StDecode: begin
                if (dec.illegal) begin
                    state_d = StTrap;
                    cause_d = 1'b0;
                end else if (dec.is_jump) begin
                    PCWrite  = 1'b1;
                    NPCOp    = NpcJump;
                    retire   = 1'b1;
                    RegWrite = dec.is_jal;
                    GPRSel   = dec.is_jal ? GprRa : GprRd;
                    WDSel    = dec.is_jal ? WdPc : WdAlu;
                    state_d  = StFetch;
                end else begin
                    state_d = StExec;
                end
            end
            StExec: begin
                ALUOp   = ALUOP_W'(dec.alu_op);
                ALUSrc  = dec.alu_src;
                AregSel = dec.areg_sel;
                EXTOp   = dec.ext_op;
                if (dec.is_branch) begin
                    PCWrite = dec.is_bne ? ~Zero : Zero;
                    NPCOp   = NpcBranch;
                    retire  = 1'b1;
                    state_d = StFetch;
                end else if (dec.is_jr || dec.is_jalr) begin
                    PCWrite  = 1'b1;
                    NPCOp    = NpcJreg;
                    retire   = 1'b1;
                    RegWrite = dec.is_jalr;
                    WDSel    = dec.is_jalr ? WdPc : WdAlu;
                    state_d  = StFetch;
                end else if (dec.is_load || dec.is_store) begin
                    state_d = StMem;
                end else begin
                    state_d = StAluWb;
                end
            end
            StMem: begin
                MemRead     = dec.is_load;
                MemWrite    = dec.is_store;
                MemWidth    = dec.mem_width;
                MemUnsigned = dec.mem_unsigned;
                if (mem_ready) begin
                    retire  = dec.is_store;
                    state_d = dec.is_load ? StMemWb : StFetch;
                end else if (cnt_q == CntLast) begin
                    state_d = StTrap;
                    cause_d = 1'b1;
                end
            end
            StMemWb: begin
                RegWrite = 1'b1;
                GPRSel   = GprRt;
                WDSel    = WdMem;
                retire   = 1'b1;
                state_d  = StFetch;
            end
            StAluWb: begin
                ALUOp    = ALUOP_W'(dec.alu_op);
                ALUSrc   = dec.alu_src;
                AregSel  = dec.areg_sel;
                EXTOp    = dec.ext_op;
                RegWrite = 1'b1;
                GPRSel   = dec.is_rtype ? GprRd : GprRt;
                retire   = 1'b1;
                state_d  = StFetch;
            end
            StTrap: begin
                trap       = 1'b1;
                trap_cause = cause_q;
            end
            default: state_d = StFetch;
        endcase

        // Counter restarts on every state change, so it is zero on entry to FETCH/MEM.
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if ((state_q == StFetch || state_q == StMem) && !mem_ready) begin
            cnt_d = cnt_q + 1'b1;
        end

        if (!rstn) begin
            PCWrite = 1'b0; NPCOp = '0; IRWrite = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
            MemWidth = '0; MemUnsigned = 1'b0; RegWrite = 1'b0; GPRSel = '0; WDSel = '0;
            ALUSrc = 1'b0; AregSel = 1'b0; EXTOp = 1'b0; ALUOp = '0; retire = 1'b0;
            trap = 1'b0; trap_cause = 1'b0;
        end
    end

endmodule

// File: tb/tb_mc_ctrl.sv
// Scoreboard bench for mc_ctrl: per-cycle expected output vectors are queued with
// the mem_ready stimulus and compared at the falling edge of each cycle.
module tb_mc_ctrl;

    typedef struct packed {
        logic       pcw;
        logic [1:0] npc;
        logic       irw;
        logic       mrd;
        logic       mwr;
        logic [1:0] mwid;
        logic       muns;
        logic       regw;
        logic [1:0] gpr;
        logic [1:0] wd;
        logic       asrc;
        logic       areg;
        logic       ext;
        logic [3:0] aop;
        logic       ret;
        logic       trp;
        logic       tcause;
    } ov_t;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic [5:0] Op = '0;
    logic [5:0] Funct = '0;
    logic       Zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       PCWrite, IRWrite, MemRead, MemWrite, MemUnsigned, RegWrite;
    logic       ALUSrc, AregSel, EXTOp, retire, trap, trap_cause;
    logic [1:0] NPCOp, MemWidth, GPRSel, WDSel;
    logic [3:0] ALUOp;
    ov_t        obs;

    int n_vec = 0;
    int n_err = 0;

    logic  rdy_q[$];
    ov_t   exp_q[$];
    string tag_q[$];

    mc_ctrl #(.ALUOP_W(4), .TIMEOUT(16)) dut (
        .clk(clk), .rstn(rstn), .Op(Op), .Funct(Funct), .Zero(Zero), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .NPCOp(NPCOp), .IRWrite(IRWrite), .MemRead(MemRead),
        .MemWrite(MemWrite), .MemWidth(MemWidth), .MemUnsigned(MemUnsigned),
        .RegWrite(RegWrite), .GPRSel(GPRSel), .WDSel(WDSel), .ALUSrc(ALUSrc),
        .AregSel(AregSel), .EXTOp(EXTOp), .ALUOp(ALUOp), .retire(retire), .trap(trap),
        .trap_cause(trap_cause)
    );

    always #5 clk = ~clk;

    always_comb begin
        obs = '0;
        obs.pcw = PCWrite; obs.npc = NPCOp; obs.irw = IRWrite; obs.mrd = MemRead;
        obs.mwr = MemWrite; obs.mwid = MemWidth; obs.muns = MemUnsigned; obs.regw = RegWrite;
        obs.gpr = GPRSel; obs.wd = WDSel; obs.asrc = ALUSrc; obs.areg = AregSel;
        obs.ext = EXTOp; obs.aop = ALUOp; obs.ret = retire; obs.trp = trap;
        obs.tcause = trap_cause;
    end

    task automatic check_eq(input string tag, input logic [23:0] got, input logic [23:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %06h expected %06h", tag, got, exp);
        end
    endtask

    function automatic logic rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic push(input logic rdy, input ov_t o, input string tag);
        rdy_q.push_back(rdy);
        exp_q.push_back(o);
        tag_q.push_back(tag);
    endtask

    task automatic q_fetch(input string tag, input int waits);
        ov_t o;
        o = '0; o.mrd = 1'b1;
        for (int i = 0; i < waits; i++) push(1'b0, o, {tag, "/fetch_wait"});
        o.irw = 1'b1; o.pcw = 1'b1;
        push(1'b1, o, {tag, "/fetch"});
    endtask

    task automatic q_alu(input string tag, input int fw, input logic [3:0] aop,
                         input logic src, input logic areg, input logic ext,
                         input logic [1:0] gpr);
        ov_t o;
        q_fetch(tag, fw);
        o = '0;
        push(rnd(), o, {tag, "/decode"});
        o.aop = aop; o.asrc = src; o.areg = areg; o.ext = ext;
        push(rnd(), o, {tag, "/exec"});
        o.regw = 1'b1; o.gpr = gpr; o.wd = 2'b00; o.ret = 1'b1;
        push(rnd(), o, {tag, "/aluwb"});
    endtask

    task automatic q_mem(input string tag, input logic load, input logic [1:0] width,
                         input logic uns, input int waits);
        ov_t o;
        q_fetch(tag, 0);
        o = '0;
        push(rnd(), o, {tag, "/decode"});
        o.aop = 4'd1; o.asrc = 1'b1; o.ext = 1'b1;
        push(rnd(), o, {tag, "/exec"});
        o = '0; o.mrd = load; o.mwr = !load; o.mwid = width; o.muns = uns;
        for (int i = 0; i < waits; i++) push(1'b0, o, {tag, "/mem_wait"});
        o.ret = !load;
        push(1'b1, o, {tag, "/mem"});
        if (load) begin
            o = '0; o.regw = 1'b1; o.gpr = 2'b01; o.wd = 2'b01; o.ret = 1'b1;
            push(rnd(), o, {tag, "/memwb"});
        end
    endtask

    task automatic q_branch(input string tag, input logic taken);
        ov_t o;
        q_fetch(tag, 0);
        o = '0;
        push(rnd(), o, {tag, "/decode"});
        o.aop = 4'd2; o.ext = 1'b1; o.npc = 2'b01; o.pcw = taken; o.ret = 1'b1;
        push(rnd(), o, {tag, "/exec"});
    endtask

    task automatic q_jump(input string tag, input logic link);
        ov_t o;
        q_fetch(tag, 0);
        o = '0; o.pcw = 1'b1; o.npc = 2'b10; o.ret = 1'b1;
        if (link) begin o.regw = 1'b1; o.gpr = 2'b10; o.wd = 2'b10; end
        push(rnd(), o, {tag, "/decode"});
    endtask

    task automatic q_jr(input string tag, input logic link);
        ov_t o;
        q_fetch(tag, 0);
        o = '0;
        push(rnd(), o, {tag, "/decode"});
        o.pcw = 1'b1; o.npc = 2'b11; o.ret = 1'b1;
        if (link) begin o.regw = 1'b1; o.gpr = 2'b00; o.wd = 2'b10; end
        push(rnd(), o, {tag, "/exec"});
    endtask

    task automatic q_trap(input string tag, input logic cause, input int n);
        ov_t o;
        o = '0; o.trp = 1'b1; o.tcause = cause;
        for (int i = 0; i < n; i++) push(rnd(), o, {tag, "/trap"});
    endtask

    task automatic drain();
        ov_t   e;
        string t;
        while (exp_q.size() > 0) begin
            mem_ready = rdy_q.pop_front();
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            @(negedge clk);
            check_eq(t, obs, e);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset(input string tag);
        rstn = 1'b0;
        mem_ready = rnd();
        #1;
        check_eq({tag, "/rst_outs"}, obs, '0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        mem_ready = 1'b0;
    endtask

    initial begin
        ov_t o;
        @(posedge clk);
        #1;
        do_reset("init");

        Op = 6'h00; Funct = 6'h20; q_alu("add", 0, 4'd1, 1'b0, 1'b0, 1'b0, 2'b00); drain();
        Funct = 6'h22; q_alu("sub", 0, 4'd2, 1'b0, 1'b0, 1'b0, 2'b00); drain();
        Funct = 6'h00; q_alu("sll", 0, 4'd7, 1'b0, 1'b1, 1'b0, 2'b00); drain();
        Funct = 6'h07; q_alu("srav", 0, 4'd9, 1'b0, 1'b0, 1'b0, 2'b00); drain();
        Funct = 6'h2B; q_alu("sltu", 0, 4'd6, 1'b0, 1'b0, 1'b0, 2'b00); drain();
        Funct = 6'h27; q_alu("nor", 0, 4'd10, 1'b0, 1'b0, 1'b0, 2'b00); drain();
        Op = 6'h0D; q_alu("ori", 0, 4'd4, 1'b1, 1'b0, 1'b0, 2'b01); drain();
        Op = 6'h08; q_alu("addi", 0, 4'd1, 1'b1, 1'b0, 1'b1, 2'b01); drain();
        Op = 6'h0F; q_alu("lui", 0, 4'd12, 1'b1, 1'b0, 1'b0, 2'b01); drain();
        Op = 6'h0A; q_alu("slti", 0, 4'd5, 1'b1, 1'b0, 1'b1, 2'b01); drain();

        Op = 6'h24; q_mem("lbu", 1'b1, 2'b10, 1'b1, 3); drain();
        Op = 6'h23; q_mem("lw", 1'b1, 2'b00, 1'b0, 0); drain();
        Op = 6'h21; q_mem("lh", 1'b1, 2'b01, 1'b0, 1); drain();
        Op = 6'h2B; q_mem("sw", 1'b0, 2'b00, 1'b0, 2); drain();
        Op = 6'h28; q_mem("sb", 1'b0, 2'b10, 1'b0, 0); drain();

        Op = 6'h04; Zero = 1'b1; q_branch("beq_z1", 1'b1); drain();
        Zero = 1'b0; q_branch("beq_z0", 1'b0); drain();
        Op = 6'h05; Zero = 1'b0; q_branch("bne_z0", 1'b1); drain();
        Zero = 1'b1; q_branch("bne_z1", 1'b0); drain();
        Zero = 1'b0;

        Op = 6'h02; q_jump("j", 1'b0); drain();
        Op = 6'h03; q_jump("jal", 1'b1); drain();
        Op = 6'h00; Funct = 6'h08; q_jr("jr", 1'b0); drain();
        Funct = 6'h09; q_jr("jalr", 1'b1); drain();

        // Ready arrives in the 16th fetch cycle: must not trap.
        Funct = 6'h24; q_alu("and_late", 15, 4'd3, 1'b0, 1'b0, 1'b0, 2'b00); drain();

        Op = 6'h3F; q_fetch("ill_op", 0); o = '0; push(rnd(), o, "ill_op/decode");
        q_trap("ill_op", 1'b0, 5); drain();
        do_reset("ill_op");

        Op = 6'h00; Funct = 6'h01; q_fetch("ill_fn", 0); o = '0; push(rnd(), o, "ill_fn/decode");
        q_trap("ill_fn", 1'b0, 3); drain();
        do_reset("ill_fn");

        Funct = 6'h20; o = '0; o.mrd = 1'b1;
        for (int i = 0; i < 16; i++) push(1'b0, o, "tmo_fetch/wait");
        q_trap("tmo_fetch", 1'b1, 5); drain();
        do_reset("tmo_fetch");

        Op = 6'h23; q_fetch("tmo_mem", 0); o = '0; push(rnd(), o, "tmo_mem/decode");
        o.aop = 4'd1; o.asrc = 1'b1; o.ext = 1'b1; push(rnd(), o, "tmo_mem/exec");
        o = '0; o.mrd = 1'b1;
        for (int i = 0; i < 16; i++) push(1'b0, o, "tmo_mem/wait");
        q_trap("tmo_mem", 1'b1, 3); drain();
        do_reset("tmo_mem");

        // Reset in the middle of a store's memory phase.
        Op = 6'h2B; q_fetch("sw_rst", 0); o = '0; push(rnd(), o, "sw_rst/decode");
        o.aop = 4'd1; o.asrc = 1'b1; o.ext = 1'b1; push(rnd(), o, "sw_rst/exec");
        o = '0; o.mwr = 1'b1;
        push(1'b0, o, "sw_rst/mem_wait"); push(1'b0, o, "sw_rst/mem_wait"); drain();
        rstn = 1'b0;
        #1;
        check_eq("sw_rst/abort", obs, '0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        mem_ready = 1'b0;
        @(negedge clk);
        o = '0; o.mrd = 1'b1;
        check_eq("sw_rst/post_fetch", obs, o);
        @(posedge clk);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
